amber128_dmem_arb: RTL and testbench

Two-requester arbiter and transaction sequencer for the single 128-bit data-memory port. The core LD128/ST128 path and the debug port each present a request. The block grants one owner at a time, sequences the DMEM request/grant/response handshake with one transaction outstanding, and routes the response, including DMEM misalign/bounds flags and a local timeout, back to the owner. It sits between the execute stage's memory request and DMEM.

---
 rtl/amber128_pkg.sv | 24 ++
 rtl/amber128_arb_pick.sv | 40 ++++
 rtl/amber128_dmem_arb.sv | 175 +++++++++++++++++
 tb/tb_amber128_dmem_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amber128_pkg.sv
// Shared amber128 types for the DMEM request/response path and arbiter ownership.
package amber128_pkg;

    typedef struct packed {
        logic         we;
        logic [63:0]  addr;
        logic [127:0] wdata;
    } amber128_dmem_req_s;

    typedef struct packed {
        logic [127:0] rdata;
        logic [2:0]   err;
    } amber128_dmem_rsp_s;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DBG  = 1'b1
    } amber128_arb_owner_e;

    localparam int DMEM_ERR_MISALIGN = 0;
    localparam int DMEM_ERR_BOUNDS   = 1;
    localparam int DMEM_ERR_TIMEOUT  = 2;

endpackage

// File: rtl/amber128_arb_pick.sv
// Two-way tie resolver. With AMBER128_DMEM_ARB_RR_EN it alternates on ties using a
// last-owner register; otherwise the core always wins.
module amber128_arb_pick
    import amber128_pkg::*;
(
`ifdef AMBER128_DMEM_ARB_RR_EN
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                upd_i,
`endif
    input  logic                core_req_i,
    input  logic                dbg_req_i,
    output amber128_arb_owner_e owner_o
);

`ifdef AMBER128_DMEM_ARB_RR_EN
    amber128_arb_owner_e last_owner;

    always_comb begin
        owner_o = OWNER_CORE;
        if (core_req_i && dbg_req_i) begin
            owner_o = (last_owner == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
        end else if (dbg_req_i) begin
            owner_o = OWNER_DBG;
        end
    end

    // Reset to DBG so the first tie after reset goes to the core.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner <= OWNER_DBG;
        end else if (upd_i) begin
            last_owner <= owner_o;
        end
    end
`else
    assign owner_o = (dbg_req_i && !core_req_i) ? OWNER_DBG : OWNER_CORE;
`endif

endmodule

// File: rtl/amber128_dmem_arb.sv
// Core/debug arbiter and single-outstanding sequencer for the 128-bit DMEM port.
// Tie policy selected by AMBER128_DMEM_ARB_RR_EN (round-robin) or fixed core priority.
module amber128_dmem_arb
    import amber128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         core_req_i,
    input  logic         core_we_i,
    input  logic [63:0]  core_addr_i,
    input  logic [127:0] core_wdata_i,
    output logic         core_gnt_o,
    output logic         core_rvalid_o,
    output logic [127:0] core_rdata_o,
    output logic [2:0]   core_err_o,
    input  logic         dbg_req_i,
    input  logic         dbg_we_i,
    input  logic [63:0]  dbg_addr_i,
    input  logic [127:0] dbg_wdata_i,
    output logic         dbg_gnt_o,
    output logic         dbg_rvalid_o,
    output logic [127:0] dbg_rdata_o,
    output logic [2:0]   dbg_err_o,
    output logic         dmem_req_o,
    output logic         dmem_we_o,
    output logic [63:0]  dmem_addr_o,
    output logic [127:0] dmem_wdata_o,
    input  logic         dmem_gnt_i,
    input  logic         dmem_rvalid_i,
    input  logic [127:0] dmem_rdata_i,
    input  logic [1:0]   dmem_err_i,
    output logic         proto_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Counter holds (cycles spent in WAIT - 1); the abort fires when it would reach the limit.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_e              state, state_nxt;
    amber128_arb_owner_e owner, pick_owner;
    amber128_dmem_req_s  req_q;
    amber128_dmem_rsp_s  core_rsp_q, dbg_rsp_q, rsp_d;
    logic [9:0]          cnt;
    logic                take, issue_gnt, rsp_fire, rsp_timeout;
    logic                core_rvalid_q, dbg_rvalid_q, proto_err_q;

    assign take = (state == IDLE) && (core_req_i || dbg_req_i);

    amber128_arb_pick u_pick (
`ifdef AMBER128_DMEM_ARB_RR_EN
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .upd_i      (take),
`endif
        .core_req_i (core_req_i),
        .dbg_req_i  (dbg_req_i),
        .owner_o    (pick_owner)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dmem_req_o  = 1'b0;
        issue_gnt   = 1'b0;
        rsp_fire    = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) begin
                    issue_gnt = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response arriving in the abort cycle still counts as a normal response.
                if (dmem_rvalid_i) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == TO_LAST) begin
                    rsp_fire    = 1'b1;
                    rsp_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_d = '0;
        if (rsp_timeout) begin
            rsp_d.err[DMEM_ERR_TIMEOUT] = 1'b1;
        end else begin
            rsp_d.rdata                  = dmem_rdata_i;
            rsp_d.err[DMEM_ERR_BOUNDS]   = dmem_err_i[DMEM_ERR_BOUNDS];
            rsp_d.err[DMEM_ERR_MISALIGN] = dmem_err_i[DMEM_ERR_MISALIGN];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner         <= OWNER_CORE;
            req_q         <= '0;
            cnt           <= '0;
            core_rsp_q    <= '0;
            dbg_rsp_q     <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            if (take) begin
                owner <= pick_owner;
                if (pick_owner == OWNER_CORE) begin
                    req_q <= '{we: core_we_i, addr: core_addr_i, wdata: core_wdata_i};
                end else begin
                    req_q <= '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
                end
            end
            if (issue_gnt) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 10'd1;
            end
            if (rsp_fire) begin
                if (owner == OWNER_CORE) begin
                    core_rsp_q    <= rsp_d;
                    core_rvalid_q <= 1'b1;
                end else begin
                    dbg_rsp_q    <= rsp_d;
                    dbg_rvalid_q <= 1'b1;
                end
            end
            // Stray or late DMEM responses are dropped but remembered.
            if (dmem_rvalid_i && (state != WAIT)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign dmem_we_o     = req_q.we;
    assign dmem_addr_o   = req_q.addr;
    assign dmem_wdata_o  = req_q.wdata;
    assign core_gnt_o    = issue_gnt && (owner == OWNER_CORE);
    assign dbg_gnt_o     = issue_gnt && (owner == OWNER_DBG);
    assign core_rvalid_o = core_rvalid_q;
    assign dbg_rvalid_o  = dbg_rvalid_q;
    assign core_rdata_o  = core_rsp_q.rdata;
    assign core_err_o    = core_rsp_q.err;
    assign dbg_rdata_o   = dbg_rsp_q.rdata;
    assign dbg_err_o     = dbg_rsp_q.err;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_amber128_dmem_arb.sv
// Directed self-checking bench for amber128_dmem_arb with TIMEOUT_CYCLES=8.
module tb_amber128_dmem_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         core_req = 1'b0, core_we = 1'b0;
    logic [63:0]  core_addr = '0;
    logic [127:0] core_wdata = '0;
    logic         core_gnt, core_rvalid;
    logic [127:0] core_rdata;
    logic [2:0]   core_err;
    logic         dbg_req = 1'b0, dbg_we = 1'b0;
    logic [63:0]  dbg_addr = '0;
    logic [127:0] dbg_wdata = '0;
    logic         dbg_gnt, dbg_rvalid;
    logic [127:0] dbg_rdata;
    logic [2:0]   dbg_err;
    logic         dmem_req, dmem_we;
    logic [63:0]  dmem_addr;
    logic [127:0] dmem_wdata;
    logic         dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [127:0] dmem_rdata = '0;
    logic [1:0]   dmem_err = '0;
    logic         proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    amber128_dmem_arb #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata), .core_err_o(core_err),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
        .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err), .proto_err_o(proto_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dmem_req"}, 128'(dmem_req), 128'd0);
        chk({tag, "_dmem_we"}, 128'(dmem_we), 128'd0);
        chk({tag, "_dmem_addr"}, 128'(dmem_addr), 128'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 128'd0);
        chk({tag, "_gnts"}, 128'({core_gnt, dbg_gnt}), 128'd0);
        chk({tag, "_rvalids"}, 128'({core_rvalid, dbg_rvalid}), 128'd0);
        chk({tag, "_core_rdata"}, core_rdata, 128'd0);
        chk({tag, "_dbg_rdata"}, dbg_rdata, 128'd0);
        chk({tag, "_errs"}, 128'({core_err, dbg_err}), 128'd0);
        chk({tag, "_proto"}, 128'(proto_err), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_dbg;
        logic [127:0] beef;
        beef = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;

        // Reset state, checked while rst is still asserted.
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Core LD128 to 0x40, zero-wait grant, response two cycles later.
        core_req = 1'b1; core_we = 1'b0; core_addr = 64'h40;
        tick();
        chk("ld_dmem_req", 128'(dmem_req), 128'd1);
        chk("ld_dmem_addr", 128'(dmem_addr), 128'h40);
        chk("ld_dmem_we", 128'(dmem_we), 128'd0);
        dmem_gnt = 1'b1;
        #1;
        chk("ld_core_gnt", 128'(core_gnt), 128'd1);
        chk("ld_dbg_gnt", 128'(dbg_gnt), 128'd0);
        tick();
        dmem_gnt = 1'b0; core_req = 1'b0;
        chk("ld_req_drop", 128'(dmem_req), 128'd0);
        chk("ld_gnt_drop", 128'(core_gnt), 128'd0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = beef; dmem_err = 2'b00;
        chk("ld_no_early_rvalid", 128'(core_rvalid), 128'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("ld_core_rvalid", 128'(core_rvalid), 128'd1);
        chk("ld_core_rdata", core_rdata, beef);
        chk("ld_core_err", 128'(core_err), 128'd0);
        chk("ld_dbg_rvalid", 128'(dbg_rvalid), 128'd0);
        chk("ld_dbg_rdata", dbg_rdata, 128'd0);
        tick();
        chk("ld_rvalid_pulse", 128'(core_rvalid), 128'd0);
        chk("ld_rdata_hold", core_rdata, beef);
        chk("ld_proto", 128'(proto_err), 128'd0);

        // Both request together, four times in a row.
        do_reset();
        core_req = 1'b1; core_addr = 64'h100;
        dbg_req  = 1'b1; dbg_addr  = 64'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
`ifdef AMBER128_DMEM_ARB_RR_EN
            exp_dbg = (i % 2 == 1);
`else
            exp_dbg = 1'b0;
`endif
            chk($sformatf("tie%0d_addr", i), 128'(dmem_addr), exp_dbg ? 128'h200 : 128'h100);
            dmem_gnt = 1'b1;
            #1;
            chk($sformatf("tie%0d_core_gnt", i), 128'(core_gnt), 128'(!exp_dbg));
            chk($sformatf("tie%0d_dbg_gnt", i), 128'(dbg_gnt), 128'(exp_dbg));
            tick();
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b1; dmem_rdata = 128'(i + 16); dmem_err = 2'b00;
            tick();
            dmem_rvalid = 1'b0;
            if (i == 3) begin
                core_req = 1'b0; dbg_req = 1'b0;
            end
            chk($sformatf("tie%0d_rvalids", i), 128'({core_rvalid, dbg_rvalid}),
                exp_dbg ? 128'b01 : 128'b10);
            chk($sformatf("tie%0d_rdata", i), exp_dbg ? dbg_rdata : core_rdata, 128'(i + 16));
            tick();
        end
        chk("tie_idle", 128'(dmem_req), 128'd0);

        // Debug ST128 never answered: abort nine cycles after the grant.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h80; dbg_wdata = 128'hA5A5;
        tick();
        chk("to_dmem_we", 128'(dmem_we), 128'd1);
        chk("to_dmem_wdata", dmem_wdata, 128'hA5A5);
        dmem_gnt = 1'b1;
        #1;
        chk("to_dbg_gnt", 128'(dbg_gnt), 128'd1);
        tick();
        dmem_gnt = 1'b0; dbg_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("to_wait%0d", k), 128'(dbg_rvalid), 128'd0);
            tick();
        end
        chk("to_rvalid", 128'(dbg_rvalid), 128'd1);
        chk("to_err", 128'(dbg_err), 128'b100);
        chk("to_rdata", dbg_rdata, 128'd0);
        chk("to_proto_before", 128'(proto_err), 128'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 128'hBAD;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_proto", 128'(proto_err), 128'd1);
        chk("late_no_rvalid", 128'({core_rvalid, dbg_rvalid}), 128'd0);
        tick();
        tick();
        chk("late_proto_sticky", 128'(proto_err), 128'd1);
        do_reset();
        chk("proto_cleared", 128'(proto_err), 128'd0);

        // Core ST128 to 0x48 answered with misalign.
        core_req = 1'b1; core_we = 1'b1; core_addr = 64'h48; core_wdata = 128'hFEED_F00D;
        tick();
        chk("st_addr", 128'(dmem_addr), 128'h48);
        chk("st_wdata", dmem_wdata, 128'hFEED_F00D);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; core_req = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 128'h77; dmem_err = 2'b01;
        tick();
        dmem_rvalid = 1'b0; dmem_err = 2'b00;
        chk("st_rvalid", 128'(core_rvalid), 128'd1);
        chk("st_err", 128'(core_err), 128'b001);

        // Response in the would-be abort cycle wins over the timeout.
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 64'h50;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; core_req = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        chk("race_no_early", 128'(core_rvalid), 128'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 128'h1234; dmem_err = 2'b10;
        tick();
        dmem_rvalid = 1'b0; dmem_err = 2'b00;
        chk("race_rvalid", 128'(core_rvalid), 128'd1);
        chk("race_err", 128'(core_err), 128'b010);
        chk("race_rdata", core_rdata, 128'h1234);
        tick();
        chk("race_single_pulse", 128'(core_rvalid), 128'd0);
        chk("race_proto", 128'(proto_err), 128'd0);

        // Reset during WAIT drops the transaction.
        core_req = 1'b1; core_addr = 64'h60;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; core_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("midrst_quiet%0d", k), 128'({core_rvalid, dbg_rvalid}), 128'd0);
            tick();
        end
        core_req = 1'b1; core_addr = 64'h70;
        tick();
        chk("post_rst_addr", 128'(dmem_addr), 128'h70);
        dmem_gnt = 1'b1;
        #1;
        chk("post_rst_gnt", 128'(core_gnt), 128'd1);
        tick();
        dmem_gnt = 1'b0; core_req = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 128'hC0FFEE;
        tick();
        dmem_rvalid = 1'b0;
        chk("post_rst_rvalid", 128'(core_rvalid), 128'd1);
        chk("post_rst_rdata", core_rdata, 128'hC0FFEE);
        chk("post_rst_err", 128'(core_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
